arcade_video_src: RTL and testbench
===================================

// Module: arcade_video_src
// PURPOSE
//  Pixel-timing generator and framebuffer reader: the source side of the arcade video path. Produces
//  ce_pix, HSync/VSync/HBlank/VBlank and RGB pixels in the exact form arcade_video consumes.
//  Fetches pixels from a linear DW-bit framebuffer (BRAM, 1-clk read latency) in raster order.
// PARAMETERS
//  DW        8    pixel width (6/8/9/12/24, same packing as arcade_video)
//  CE_DIV    4    clk_video cycles per pixel; must be >=2
//  H_ACTIVE  320  visible pixels/line;  H_FP 8, H_SYNC 32, H_BP 40: porch/sync widths in pixels
//  V_ACTIVE  240  visible lines/frame;  V_FP 3, V_SYNC 4,  V_BP 15: porch/sync widths in lines
//  (derived) H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise, AW=$clog2(H_ACTIVE*V_ACTIVE)
// PORTS
//  clk_video    in   1   video clock
//  reset_n      in   1   asynchronous, active-low reset
//  enable       in   1   level; start/stop generation on frame boundaries
//  fb_rd        out  1   one-clk read strobe to framebuffer
//  fb_addr      out  AW  framebuffer word address, row-major, 0 = top-left
//  fb_data      in   DW  read data, valid exactly 1 clk after fb_rd
//  ce_pix       out  1   one-clk pulse every CE_DIV clocks
//  RGB_out      out  DW  pixel; 0 whenever HBlank|VBlank
//  HBlank/VBlank out 1   active-high blanks
//  HSync/VSync  out  1   active-high syncs
//  hcount       out  16  current pixel column; vcount out 16 current line
//  frame_start  out  1   one-clk pulse (with ce_pix) when pixel (0,0) is presented
// BEHAVIOUR
//  Reset: all outputs 0, divider=0, hcnt=vcnt=0, addr=0, state IDLE.
//  Divider: div counts 0..CE_DIV-1 free-running (also in IDLE); tick = (div==CE_DIV-1); ce_pix<=tick.
//  FSM: IDLE -> RUN on tick with enable=1 (hcnt=vcnt=0 first presented pixel).
//   RUN -> IDLE on tick where hcnt=H_TOTAL-1, vcnt=V_TOTAL-1 and enable=0 (always a full frame).
//   enable dropping and re-rising mid-frame: no effect. IDLE: counters held 0, HBlank=VBlank=1,
//   syncs 0, fb_rd 0, ce_pix keeps pulsing.
//  Counters (RUN, on tick): hcnt wraps H_TOTAL-1->0; on wrap vcnt++ wrapping V_TOTAL-1->0.
//  Fetch: at tick cycle for an active pixel (hcnt<H_ACTIVE, vcnt<V_ACTIVE) assert fb_rd with fb_addr;
//   fb_data captured next clk into a holding reg. Address counter resets to 0 at frame start, +1 per
//   fetched pixel; never exceeds H_ACTIVE*V_ACTIVE-1.
//  Output latency: pixel (h,v) fetched at tick N appears on all outputs at tick N+1 (1 pixel);
//   RGB_out, HBlank, VBlank, HSync, VSync, hcount, vcount all update together on the ce_pix clk only.
//  HBlank=(h>=H_ACTIVE); VBlank=(v>=V_ACTIVE): VBlank changes on same clk HBlank falls (h=0), as the
//   downstream latches VBlank at HBlank falling edge.
//  HSync=(H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC); VSync=(V_ACTIVE+V_FP <= v < +V_SYNC), VSync
//   changes only at h=0, so it is stable at HSync rising edge (downstream sample point).
//  Widths: h/v counters 16-bit unsigned; compare against parameters zero-extended.
//  reset_n assertion mid-frame: immediate async return to reset values; restart needs enable.
// STRUCTURE
//  Shared package arcade_video_pkg: DW packing constants, video_timing_t struct (active/fp/sync/bp).
//  Sub-module video_timing_counter (div, hcnt, vcnt, region flags); top holds FSM, fetch, output regs.
// TESTING  (DW=8, CE_DIV=2, H 8/2/2/2 => H_TOTAL 14, V 4/1/1/1 => V_TOTAL 7, fb[i]=i+1)
//  Reset then enable=1 -> first ce_pix after start: frame_start=1, RGB_out=8'h01, HBlank=VBlank=0.
//  Line 0 -> RGB 1..8 on consecutive ce_pix, then HBlank=1 for 6 pixels, HSync=1 at h=10,11 only.
//  Full frame -> fb_rd count=32, max fb_addr=31, VSync=1 for exactly line 5, VBlank lines 4..6.
//  enable=0 at line 2 -> frame completes to vcnt=6,hcnt=13 then IDLE; no further fb_rd.
//  CE_DIV check -> ce_pix period exactly 2 clks in IDLE and RUN; outputs change only on ce_pix clk.
//  reset_n low mid-line 3 -> same clk all outputs 0; re-enable restarts at (0,0), fb_addr=0.

Source files
------------

// File: rtl/arcade_video_pkg.sv
// -----------------------------------------------------------------------------
// arcade_video_pkg
//  Shared definitions for the arcade video path: pixel packing widths, the
//  per-axis timing description, the source FSM states and the tag that follows
//  a fetched pixel through the one-pixel output pipeline.
// -----------------------------------------------------------------------------
package arcade_video_pkg;

    // Pixel packings understood by arcade_video (bits per pixel).
    localparam int DW_RGB222 = 6;
    localparam int DW_RGB332 = 8;
    localparam int DW_RGB333 = 9;
    localparam int DW_RGB444 = 12;
    localparam int DW_RGB888 = 24;

    // One axis of raster timing, all in pixels (h) or lines (v).
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } video_timing_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vsrc_state_e;

    // Position and region flags of the pixel fetched on a tick, presented on the next tick.
    typedef struct packed {
        logic        vld;
        logic [15:0] h;
        logic [15:0] v;
        logic        hblank;
        logic        vblank;
        logic        hsync;
        logic        vsync;
    } pix_tag_t;

    function automatic logic [15:0] vt_total(input video_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic logic [15:0] vt_sync_start(input video_timing_t t);
        return t.active + t.fp;
    endfunction

    function automatic logic [15:0] vt_sync_end(input video_timing_t t);
        return t.active + t.fp + t.sync;
    endfunction

    function automatic bit dw_supported(input int dw);
        return (dw == DW_RGB222) || (dw == DW_RGB332) || (dw == DW_RGB333) ||
               (dw == DW_RGB444) || (dw == DW_RGB888);
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// -----------------------------------------------------------------------------
// video_timing_counter
//  Free-running pixel-clock divider plus raster h/v counters and region flags.
//  Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   run_i              1: advance counters on tick; 0: hold both counters at 0
//   tick_o             high on the last clk of each CE_DIV-clk pixel period
//   hcnt_o, vcnt_o     current raster position
//   active_o           position is inside the visible area
//   hblank_o/vblank_o  horizontal / vertical blanking region
//   hsync_o/vsync_o    horizontal / vertical sync region
//   frame_end_o        position is the last pixel of the frame
// -----------------------------------------------------------------------------
module video_timing_counter
    import arcade_video_pkg::*;
#(
    parameter int            CE_DIV = 4,
    parameter video_timing_t H_TIM  = '{active: 16'd320, fp: 16'd8, sync: 16'd32, bp: 16'd40},
    parameter video_timing_t V_TIM  = '{active: 16'd240, fp: 16'd3, sync: 16'd4,  bp: 16'd15}
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    output logic        tick_o,
    output logic [15:0] hcnt_o,
    output logic [15:0] vcnt_o,
    output logic        active_o,
    output logic        hblank_o,
    output logic        vblank_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_end_o
);

    localparam int              DIVW     = $clog2(CE_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CE_DIV - 1);
    localparam logic [15:0]     H_LAST   = vt_total(H_TIM) - 16'd1;
    localparam logic [15:0]     V_LAST   = vt_total(V_TIM) - 16'd1;
    localparam logic [15:0]     HS_BEG   = vt_sync_start(H_TIM);
    localparam logic [15:0]     HS_END   = vt_sync_end(H_TIM);
    localparam logic [15:0]     VS_BEG   = vt_sync_start(V_TIM);
    localparam logic [15:0]     VS_END   = vt_sync_end(V_TIM);

    logic [DIVW-1:0] div_q;
    logic [15:0]     hcnt_q;
    logic [15:0]     vcnt_q;

    assign tick_o = (div_q == DIV_LAST);

    // Divider runs regardless of run_i so ce_pix keeps pulsing while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
        end else begin
            div_q <= tick_o ? '0 : div_q + DIVW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (!run_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (tick_o) begin
            if (hcnt_q == H_LAST) begin
                hcnt_q <= '0;
                vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + 16'd1;
            end else begin
                hcnt_q <= hcnt_q + 16'd1;
            end
        end
    end

    assign hcnt_o      = hcnt_q;
    assign vcnt_o      = vcnt_q;
    assign hblank_o    = (hcnt_q >= H_TIM.active);
    assign vblank_o    = (vcnt_q >= V_TIM.active);
    assign active_o    = !hblank_o && !vblank_o;
    assign hsync_o     = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    assign vsync_o     = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    assign frame_end_o = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule

// File: rtl/arcade_video_src.sv
// -----------------------------------------------------------------------------
// arcade_video_src
//  Raster timing generator and linear framebuffer reader feeding arcade_video.
//  Ports:
//   clk_video, reset_n   video clock, async active-low reset
//   enable               start/stop request, honoured only on frame boundaries
//   fb_rd, fb_addr       one-clk read strobe and row-major word address
//   fb_data              read data, valid one clk after fb_rd
//   ce_pix               one-clk pulse every CE_DIV clks
//   RGB_out              pixel, forced to 0 in blanking
//   HBlank/VBlank        active-high blanks
//   HSync/VSync          active-high syncs
//   hcount/vcount        position of the pixel on RGB_out
//   frame_start          pulse with ce_pix when pixel (0,0) is presented
//  A pixel fetched on tick N is presented on tick N+1; all video outputs
//  change together on that edge, i.e. during the ce_pix clk.
// -----------------------------------------------------------------------------
module arcade_video_src
    import arcade_video_pkg::*;
#(
    parameter  int DW       = 8,
    parameter  int CE_DIV   = 4,
    parameter  int H_ACTIVE = 320,
    parameter  int H_FP     = 8,
    parameter  int H_SYNC   = 32,
    parameter  int H_BP     = 40,
    parameter  int V_ACTIVE = 240,
    parameter  int V_FP     = 3,
    parameter  int V_SYNC   = 4,
    parameter  int V_BP     = 15,
    localparam int AW       = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic          clk_video,
    input  logic          reset_n,
    input  logic          enable,
    output logic          fb_rd,
    output logic [AW-1:0] fb_addr,
    input  logic [DW-1:0] fb_data,
    output logic          ce_pix,
    output logic [DW-1:0] RGB_out,
    output logic          HBlank,
    output logic          VBlank,
    output logic          HSync,
    output logic          VSync,
    output logic [15:0]   hcount,
    output logic [15:0]   vcount,
    output logic          frame_start
);

    localparam video_timing_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                        sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam video_timing_t V_TIM = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                        sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam logic [AW-1:0] ADDR_LAST = AW'(H_ACTIVE * V_ACTIVE - 1);

    logic        tick, active, hb, vb, hs, vs, frame_end, run, fetch;
    logic [15:0] hcnt, vcnt;

    vsrc_state_e state_q, state_d;

    logic [AW-1:0] addr_q;
    logic          rd_pend_q;
    logic [DW-1:0] hold_q;
    pix_tag_t      tag_q;

    logic          ce_pix_q, hblank_q, vblank_q, hsync_q, vsync_q, frame_start_q;
    logic [DW-1:0] rgb_q;
    logic [15:0]   hcount_q, vcount_q;

    video_timing_counter #(
        .CE_DIV (CE_DIV),
        .H_TIM  (H_TIM),
        .V_TIM  (V_TIM)
    ) u_tcnt (
        .clk_i       (clk_video),
        .rst_ni      (reset_n),
        .run_i       (run),
        .tick_o      (tick),
        .hcnt_o      (hcnt),
        .vcnt_o      (vcnt),
        .active_o    (active),
        .hblank_o    (hb),
        .vblank_o    (vb),
        .hsync_o     (hs),
        .vsync_o     (vs),
        .frame_end_o (frame_end)
    );

    // ---------------- FSM: starts/stops only between frames ----------------
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (tick && enable)                state_d = ST_RUN;
            ST_RUN:  if (tick && frame_end && !enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign run = (state_q == ST_RUN);

    // ---------------- Fetch ----------------
    assign fetch   = tick && run && active;
    assign fb_rd   = fetch;
    assign fb_addr = addr_q;

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else if (!run || (tick && frame_end)) begin
            addr_q <= '0;
        end else if (fetch) begin
            // Clamp-wrap keeps the address in range for non power-of-two frame sizes.
            addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            rd_pend_q <= fetch;
            if (rd_pend_q) hold_q <= fb_data;
        end
    end

    // Tag the fetched position; it is presented together with hold_q next tick.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= '0;
        end else if (tick) begin
            tag_q <= '{vld: run, h: hcnt, v: vcnt, hblank: hb, vblank: vb, hsync: hs, vsync: vs};
        end
    end

    // ---------------- Output stage ----------------
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            ce_pix_q      <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
        end else begin
            ce_pix_q      <= tick;
            frame_start_q <= 1'b0;
            if (tick) begin
                if (tag_q.vld) begin
                    rgb_q         <= (tag_q.hblank || tag_q.vblank) ? '0 : hold_q;
                    hblank_q      <= tag_q.hblank;
                    vblank_q      <= tag_q.vblank;
                    hsync_q       <= tag_q.hsync;
                    vsync_q       <= tag_q.vsync;
                    hcount_q      <= tag_q.h;
                    vcount_q      <= tag_q.v;
                    frame_start_q <= (tag_q.h == 16'd0) && (tag_q.v == 16'd0);
                end else begin
                    // Idle raster: fully blanked, no syncs, position parked at 0.
                    rgb_q    <= '0;
                    hblank_q <= 1'b1;
                    vblank_q <= 1'b1;
                    hsync_q  <= 1'b0;
                    vsync_q  <= 1'b0;
                    hcount_q <= '0;
                    vcount_q <= '0;
                end
            end
        end
    end

    assign ce_pix      = ce_pix_q;
    assign frame_start = frame_start_q;
    assign RGB_out     = rgb_q;
    assign HBlank      = hblank_q;
    assign VBlank      = vblank_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;

endmodule

// File: tb/tb_arcade_video_src.sv
// -----------------------------------------------------------------------------
// tb_arcade_video_src
//  Small-raster bench: H 8/2/2/2 (14 px), V 4/1/1/1 (7 lines), CE_DIV 2.
//  A pixel-level reference model predicts every output on every clk.
// -----------------------------------------------------------------------------
module tb_arcade_video_src;

    localparam int DW = 8, CE_DIV = 2;
    localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int TOT = HT * VT;
    localparam int AW = $clog2(HA * VA);

    logic          clk_video = 1'b0;
    logic          reset_n   = 1'b0;
    logic          enable    = 1'b0;
    logic          fb_rd;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;
    logic          ce_pix, HBlank, VBlank, HSync, VSync, frame_start;
    logic [DW-1:0] RGB_out;
    logic [15:0]   hcount, vcount;

    arcade_video_src #(
        .DW(DW), .CE_DIV(CE_DIV),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk_video(clk_video), .reset_n(reset_n), .enable(enable),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
        .ce_pix(ce_pix), .RGB_out(RGB_out),
        .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
        .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
    );

    always #5 clk_video = ~clk_video;

    // Framebuffer: 1-clk read latency.
    logic [7:0] fb [0:HA*VA-1];
    always @(posedge clk_video) if (fb_rd) fb_data <= fb[fb_addr];

    typedef struct {
        logic [7:0]  rgb;
        logic        hb, vb, hs, vs, fs;
        logic [15:0] hc, vc;
        bit          act;
    } exp_t;

    typedef struct {
        int         h, v;
        logic [7:0] rgb;
        logic       hb, vb, hs, vs, fs;
    } vec_t;

    int n_chk = 0, n_fail = 0;

    // Reference model state.
    int   c;          // clk index since reset release
    bit   m_run;
    int   m_n;        // next pixel index to fetch within frame
    exp_t cur, pend;
    bit   last_tick;
    int   rd_cnt, max_addr, first_addr;
    int   last_h, last_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic exp_t e_zero();
        exp_t e;
        e.rgb = 0; e.hb = 0; e.vb = 0; e.hs = 0; e.vs = 0; e.fs = 0;
        e.hc = 0; e.vc = 0; e.act = 0;
        return e;
    endfunction

    function automatic exp_t e_idle();
        exp_t e = e_zero();
        e.hb = 1'b1; e.vb = 1'b1;
        return e;
    endfunction

    // Expected presentation of pixel n of a frame, straight from the raster rules.
    function automatic exp_t pix(input int n);
        exp_t e;
        int h = n % HT;
        int v = n / HT;
        e.hc  = 16'(h);
        e.vc  = 16'(v);
        e.hb  = (h >= HA);
        e.vb  = (v >= VA);
        e.hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
        e.vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
        e.rgb = (!e.hb && !e.vb) ? fb[v * HA + h] : 8'h00;
        e.fs  = (n == 0);
        e.act = 1'b1;
        return e;
    endfunction

    function automatic vec_t mk(input int h, input int v, input int rgb,
                                input int hb, input int vb, input int hs, input int vs, input int fs);
        vec_t r;
        r.h = h; r.v = v; r.rgb = 8'(rgb);
        r.hb = (hb != 0); r.vb = (vb != 0); r.hs = (hs != 0); r.vs = (vs != 0); r.fs = (fs != 0);
        return r;
    endfunction

    task automatic model_reset();
        c = 0; m_run = 0; m_n = 0;
        cur = e_zero(); pend = e_idle();
    endtask

    // One clk: check everything mid-cycle, advance model, return at posedge+1.
    task automatic step_clk();
        bit tk, exp_ce, erd;
        int eaddr;
        exp_t nw;
        @(negedge clk_video);
        tk     = (c % CE_DIV) == CE_DIV - 1;
        exp_ce = (c >= CE_DIV) && (c % CE_DIV == 0);
        chk("ce_pix", ce_pix, exp_ce);
        chk("RGB_out", RGB_out, cur.rgb);
        chk("HBlank", HBlank, cur.hb);
        chk("VBlank", VBlank, cur.vb);
        chk("HSync", HSync, cur.hs);
        chk("VSync", VSync, cur.vs);
        chk("hcount", hcount, cur.hc);
        chk("vcount", vcount, cur.vc);
        chk("frame_start", frame_start, cur.fs & exp_ce);
        erd = 0; eaddr = 0;
        if (tk && m_run && (m_n % HT) < HA && (m_n / HT) < VA) begin
            erd = 1; eaddr = (m_n / HT) * HA + (m_n % HT);
        end
        chk("fb_rd", fb_rd, erd);
        if (erd) chk("fb_addr", fb_addr, eaddr);
        if (fb_rd) begin
            rd_cnt++;
            if (rd_cnt == 1) first_addr = int'(fb_addr);
            if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
        end
        if (ce_pix && (hcount != 0 || vcount != 0)) begin
            last_h = int'(hcount); last_v = int'(vcount);
        end
        if (tk) begin
            if (!m_run) begin
                nw = e_idle();
                if (enable) begin m_run = 1; m_n = 0; end
            end else begin
                nw = pix(m_n);
                if (m_n == TOT - 1 && !enable) m_run = 0;
                m_n = (m_n + 1) % TOT;
            end
            cur  = pend;
            pend = nw;
        end
        last_tick = tk;
        c++;
        @(posedge clk_video);
        #1;
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_RGB"}, RGB_out, 0);
        chk({tag, "_HBlank"}, HBlank, 0);
        chk({tag, "_VBlank"}, VBlank, 0);
        chk({tag, "_HSync"}, HSync, 0);
        chk({tag, "_VSync"}, VSync, 0);
        chk({tag, "_hcount"}, hcount, 0);
        chk({tag, "_vcount"}, vcount, 0);
        chk({tag, "_ce_pix"}, ce_pix, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_fb_rd"}, fb_rd, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
    endtask

    vec_t tbl [15];

    initial begin
        int g;
        // Hand-derived presentations for the first frame with fb[i]=i+1.
        //            h  v  rgb   hb vb hs vs fs
        tbl[0]  = mk(0, 0, 8'h01, 0, 0, 0, 0, 1);
        tbl[1]  = mk(1, 0, 8'h02, 0, 0, 0, 0, 0);
        tbl[2]  = mk(7, 0, 8'h08, 0, 0, 0, 0, 0);
        tbl[3]  = mk(8, 0, 8'h00, 1, 0, 0, 0, 0);
        tbl[4]  = mk(9, 0, 8'h00, 1, 0, 0, 0, 0);
        tbl[5]  = mk(10, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[6]  = mk(11, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[7]  = mk(12, 0, 8'h00, 1, 0, 0, 0, 0);
        tbl[8]  = mk(13, 0, 8'h00, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 8'h09, 0, 0, 0, 0, 0);
        tbl[10] = mk(7, 3, 8'h20, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 4, 8'h00, 0, 1, 0, 0, 0);
        tbl[12] = mk(0, 5, 8'h00, 0, 1, 0, 1, 0);
        tbl[13] = mk(11, 5, 8'h00, 1, 1, 1, 1, 0);
        tbl[14] = mk(0, 6, 8'h00, 0, 1, 0, 0, 0);

        for (int i = 0; i < HA * VA; i++) fb[i] = 8'(i + 1);
        rd_cnt = 0; max_addr = 0; first_addr = -1; last_h = 0; last_v = 0;

        // ---- reset state ----
        repeat (3) @(posedge clk_video);
        #1 zero_chk("reset");
        reset_n = 1'b1;
        model_reset();
        repeat (6) step_clk();

        // ---- first frame against the hand table ----
        enable = 1'b1;
        rd_cnt = 0; max_addr = 0;
        for (int i = 0; i < 15; i++) begin
            g = 0;
            do begin
                step_clk(); g++;
            end while (!(last_tick && cur.act && cur.hc == 16'(tbl[i].h) && cur.vc == 16'(tbl[i].v)) && g < 400);
            if (g >= 400) timeout("tbl_seek");
            else begin
                chk("tbl_RGB", RGB_out, tbl[i].rgb);
                chk("tbl_HBlank", HBlank, tbl[i].hb);
                chk("tbl_VBlank", VBlank, tbl[i].vb);
                chk("tbl_HSync", HSync, tbl[i].hs);
                chk("tbl_VSync", VSync, tbl[i].vs);
                chk("tbl_frame_start", frame_start, tbl[i].fs);
                chk("tbl_hcount", hcount, 16'(tbl[i].h));
                chk("tbl_vcount", vcount, 16'(tbl[i].v));
            end
        end

        // Up to (12,6) presented: every fetch of frame 0 done, none of frame 1.
        g = 0;
        do begin step_clk(); g++; end
        while (!(last_tick && cur.act && cur.hc == 16'd12 && cur.vc == 16'd6) && g < 400);
        if (g >= 400) timeout("frame_end_seek");
        chk("frame_rd_count", rd_cnt, 32);
        chk("frame_max_addr", max_addr, 31);

        // ---- enable dropped on line 2 of the second frame ----
        g = 0;
        do begin step_clk(); g++; end while (!(cur.act && cur.vc == 16'd2) && g < 400);
        if (g >= 400) timeout("line2_seek");
        enable = 1'b0;
        last_h = 0; last_v = 0;
        g = 0;
        do begin step_clk(); g++; end while (m_run && g < 400);
        if (g >= 400) timeout("stop_seek");
        repeat (6) step_clk();
        chk("stop_last_h", last_h, 13);
        chk("stop_last_v", last_v, 6);
        rd_cnt = 0;
        repeat (40) step_clk();
        chk("stop_no_rd", rd_cnt, 0);
        chk("idle_HBlank", HBlank, 1);
        chk("idle_VBlank", VBlank, 1);
        chk("idle_hcount", hcount, 0);

        // ---- randomized enable with random framebuffer contents ----
        for (int i = 0; i < HA * VA; i++) fb[i] = 8'($urandom);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            step_clk();
        end

        // ---- async reset in the middle of line 3 ----
        enable = 1'b1;
        g = 0;
        do begin step_clk(); g++; end while (!(m_run && m_n == 3 * HT + 4) && g < 800);
        if (g >= 800) timeout("line3_seek");
        reset_n = 1'b0;
        #1 zero_chk("midrst");
        enable = 1'b0;
        repeat (3) @(posedge clk_video);
        #1 reset_n = 1'b1;
        model_reset();
        rd_cnt = 0; first_addr = -1;
        repeat (10) step_clk();
        chk("rst_no_restart", rd_cnt, 0);
        enable = 1'b1;
        g = 0;
        do begin step_clk(); g++; end while (rd_cnt == 0 && g < 50);
        if (g >= 50) timeout("restart_seek");
        chk("restart_addr", first_addr, 0);
        repeat (220) step_clk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
